// File: rtl/atree_pkg.sv
// Shared types and width helpers for the atree adder tree and its sequencer.
package atree_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  // Number of input lanes reduced by one tree pass.
  function automatic int lanes(input int levels);
    return 1 << levels;
  endfunction

  // Width of a single tree sum: each level adds one carry bit.
  function automatic int sum_width(input int in_width, input int levels);
    return in_width + levels;
  endfunction

  // Accumulator width that cannot overflow for max_chunks tree sums.
  function automatic int acc_width(input int in_width, input int levels, input int max_chunks);
    return in_width + levels + $clog2(max_chunks);
  endfunction

endpackage

// File: rtl/atree.sv
// Combinational unsigned adder tree: reduces 2^LEVELS lanes to one sum.
module atree
  import atree_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int LEVELS   = 2
) (
  input  logic [lanes(LEVELS)-1:0][IN_WIDTH-1:0] in_data,
  output logic [sum_width(IN_WIDTH, LEVELS)-1:0]  sum
);

  localparam int L  = lanes(LEVELS);
  localparam int SW = sum_width(IN_WIDTH, LEVELS);

  // Level 0 holds the zero-extended lanes; each further level halves the node count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [SW-1:0] s [L >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < L; i++) begin : g_in
        assign s[i] = SW'(in_data[i]);
      end
    end else begin : g_add
      for (genvar i = 0; i < (L >> l); i++) begin : g_sum
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign sum = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/atree_seq.sv
// Sequencer: streams cfg_chunks beats through one atree, accumulates the
// registered per-beat sums and returns the total over a valid/ready port.
module atree_seq
  import atree_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int LEVELS     = 2,
  parameter int MAX_CHUNKS = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [$clog2(MAX_CHUNKS+1)-1:0]                   cfg_chunks,
  output logic                                              busy,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [lanes(LEVELS)-1:0][IN_WIDTH-1:0]            in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [acc_width(IN_WIDTH, LEVELS, MAX_CHUNKS)-1:0] out_data
);

  localparam int CW = $clog2(MAX_CHUNKS + 1);
  localparam int SW = sum_width(IN_WIDTH, LEVELS);
  localparam int AW = acc_width(IN_WIDTH, LEVELS, MAX_CHUNKS);

  state_t          state;
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   n_clamp;
  logic [CW-1:0]   cnt_inc;
  logic [SW-1:0]   tree_sum;
  logic [SW-1:0]   sum_q;
  logic            sum_v;
  logic [AW-1:0]   acc;

  atree #(
    .IN_WIDTH (IN_WIDTH),
    .LEVELS   (LEVELS)
  ) u_atree (
    .in_data (in_data),
    .sum     (tree_sum)
  );

  // Requests longer than the buffer depth are clamped rather than rejected.
  assign n_clamp = (cfg_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : cfg_chunks;
  assign cnt_inc = cnt_q + CW'(1);

  // Handshake flags decode straight from the state register (Moore outputs).
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == OUT);
  assign out_data  = acc;

  // FSM, beat counter, sum pipeline stage and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q   <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      sum_v <= 1'b0;
      acc   <= '0;
    end else begin
      // NOTE: non-blocking assignments let later branches override these
      // defaults (a new handshake reloads sum_v, a start clears acc).
      if (sum_v) acc <= acc + AW'(sum_q);
      sum_v <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= n_clamp;
            cnt_q <= '0;
            sum_q <= '0;
            sum_v <= 1'b0;
            acc   <= '0;
            state <= (n_clamp == '0) ? OUT : RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            sum_q <= tree_sum;
            sum_v <= 1'b1;
            cnt_q <= cnt_inc;
            if (cnt_inc == n_q) state <= DRAIN;
          end
        end
        DRAIN: state <= OUT;
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atree_seq.sv
// Self-checking bench for atree_seq: directed scenarios with literal results
// plus randomized traffic, all compared every cycle against a transaction-level
// model (sum of accepted lanes, beat count and cycle timestamps).
module tb_atree_seq;

  localparam int IN_WIDTH   = 8;
  localparam int LEVELS     = 2;
  localparam int MAX_CHUNKS = 16;
  localparam int LANES      = 4;
  localparam int CW         = 5;
  localparam int AW         = 14;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            start;
  logic [CW-1:0]                   cfg_chunks;
  logic                            busy;
  logic                            in_valid;
  logic                            in_ready;
  logic [LANES-1:0][IN_WIDTH-1:0]  in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [AW-1:0]                   out_data;

  atree_seq #(
    .IN_WIDTH   (IN_WIDTH),
    .LEVELS     (LEVELS),
    .MAX_CHUNKS (MAX_CHUNKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_chunks (cfg_chunks),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Transaction model state.
  bit vec_on      = 1'b0;
  int m_n         = 0;
  int m_beats     = 0;
  int m_sum       = 0;
  int last_cyc    = 0;
  int last_result = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lane_sum(input logic [LANES-1:0][IN_WIDTH-1:0] d);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += int'(d[i]);
    return s;
  endfunction

  // Compare outputs (state after the last edge), then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      bit exp_ov;
      cyc++;
      exp_rdy = vec_on && (m_beats < m_n);
      exp_ov  = vec_on && (m_beats == m_n) && ((m_n == 0) || (cyc >= last_cyc + 2));
      check("busy", int'(busy), int'(vec_on));
      check("in_ready", int'(in_ready), int'(exp_rdy));
      check("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov)       check("out_data", int'(out_data), m_sum);
      else if (!vec_on) check("out_data_idle", int'(out_data), last_result);

      if (rst) begin
        vec_on      = 1'b0;
        m_n         = 0;
        m_beats     = 0;
        m_sum       = 0;
        last_result = 0;
      end else if (!vec_on) begin
        if (start) begin
          vec_on  = 1'b1;
          m_n     = (int'(cfg_chunks) > MAX_CHUNKS) ? MAX_CHUNKS : int'(cfg_chunks);
          m_beats = 0;
          m_sum   = 0;
        end
      end else begin
        if (exp_rdy && in_valid) begin
          m_sum    += lane_sum(in_data);
          m_beats++;
          last_cyc  = cyc;
        end
        if (exp_ov && out_ready) begin
          vec_on      = 1'b0;
          last_result = m_sum;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input int cfg);
    start      = 1'b1;
    cfg_chunks = CW'(cfg);
    tick();
    start      = 1'b0;
    cfg_chunks = CW'($urandom_range(0, 31));
  endtask

  task automatic send_beat(input logic [LANES-1:0][IN_WIDTH-1:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  // Waits for out_valid (bounded), checks the literal total, reports the wait.
  task automatic wait_result(input string name, input int exp, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok     = 1'b1;
        waited = k;
        break;
      end
    end
    if (ok) check(name, int'(out_data), exp);
    else    check({name, "_timeout"}, 0, 1);
    tick();
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    start      = 1'b0;
    cfg_chunks = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: single beat, latency of two cycles after the handshake cycle.
    start_vec(1);
    send_beat({8'd65, 8'd42, 8'd37, 8'd9});
    wait_result("t1_sum", 153, w);
    check("t1_latency", w, 1);

    // 2: four back-to-back all-ones beats; in_ready low in DRAIN.
    start_vec(4);
    for (int i = 0; i < 4; i++) send_beat({4{8'hFF}});
    @(negedge clk);
    check("t2_drain_ready", int'(in_ready), 0);
    check("t2_drain_busy", int'(busy), 1);
    tick();
    wait_result("t2_sum", 4080, w);

    // 3: three beats separated by two bubble cycles.
    start_vec(3);
    send_beat({8'd1, 8'd2, 8'd3, 8'd4});
    tick(); tick();
    send_beat({8'd10, 8'd10, 8'd10, 8'd10});
    tick(); tick();
    send_beat({8'd100, 8'd0, 8'd0, 8'd0});
    wait_result("t3_sum", 150, w);

    // 4a: empty vector reports zero on the cycle after start.
    start_vec(0);
    wait_result("t4_zero_sum", 0, w);
    check("t4_zero_latency", w, 0);

    // 4b: 20 requested beats are clamped to 16.
    start_vec(20);
    for (int i = 0; i < 16; i++) send_beat({4{8'hFF}});
    in_valid = 1'b1;
    @(negedge clk);
    check("t4_clamp_ready", int'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    wait_result("t4_clamp_sum", 16320, w);

    // 5: result backpressure with an ignored start during OUT.
    out_ready = 1'b0;
    start_vec(2);
    send_beat({8'd50, 8'd50, 8'd50, 8'd50});
    send_beat({8'd1, 8'd2, 8'd3, 8'd4});
    w = 0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("t5_sum", int'(out_data), 210);
    for (int i = 0; i < 5; i++) begin
      tick();
      start      = (i == 1);
      cfg_chunks = CW'(3);
      @(negedge clk);
      check("t5_hold_valid", int'(out_valid), 1);
      check("t5_hold_data", int'(out_data), 210);
    end
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t5_idle_busy", int'(busy), 0);
    check("t5_idle_valid", int'(out_valid), 0);
    check("t5_idle_data", int'(out_data), 210);
    tick();

    // 6: reset mid-vector, then a clean vector with no stale partial sum.
    start_vec(4);
    send_beat({4{8'd77}});
    send_beat({4{8'd33}});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_ready", int'(in_ready), 0);
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_data", int'(out_data), 0);
    tick();
    start_vec(1);
    send_beat({4{8'd1}});
    wait_result("t6_sum", 4, w);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 5) == 0);
      cfg_chunks = CW'($urandom_range(0, 20));
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = $urandom;
      out_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    check("final_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
